// File: rtl/lbp_param.sv
// lbp_param: 3x3 local binary pattern engine over a 2^Y_BITS x 2^X_BITS gray image, one memory read per cycle.
// Optional macro LBP_BORDER_EN: scan every pixel and emit border pixels with code 0 and no reads.
module lbp_param #(
  parameter int X_BITS = 7,
  parameter int Y_BITS = 7,
  parameter int PIX_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PIX_W-1:0]         thresh,
  output logic                     gray_req,
  output logic [Y_BITS+X_BITS-1:0] gray_addr,
  input  logic [PIX_W-1:0]         gray_data,
  output logic                     lbp_valid,
  output logic [Y_BITS+X_BITS-1:0] lbp_addr,
  output logic [7:0]               lbp_data,
  input  logic                     lbp_ready,
  output logic                     busy,
  output logic                     finish
);
  localparam int A_W = Y_BITS + X_BITS;
  localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);
  localparam logic [X_BITS-1:0] X_END = '1;
  localparam logic [Y_BITS-1:0] Y_END = '1;
`ifdef LBP_BORDER_EN
  localparam logic [X_BITS-1:0] X_FIRST = '0;
  localparam logic [Y_BITS-1:0] Y_FIRST = '0;
  localparam logic [X_BITS-1:0] X_LAST  = X_END;
  localparam logic [Y_BITS-1:0] Y_LAST  = Y_END;
  localparam bit                FIRST_BORDER = 1'b1;
`else
  localparam logic [X_BITS-1:0] X_FIRST = X_ONE;
  localparam logic [Y_BITS-1:0] Y_FIRST = Y_ONE;
  localparam logic [X_BITS-1:0] X_LAST  = X_END - X_ONE;
  localparam logic [Y_BITS-1:0] Y_LAST  = Y_END - Y_ONE;
  localparam bit                FIRST_BORDER = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, CALC, OUT, DONE} state_t;
  state_t state, next_state;

  logic [X_BITS-1:0] x, nx_x, fx;
  logic [Y_BITS-1:0] y, nx_y, fy;
  logic [3:0]        cnt;
  logic [PIX_W-1:0]  centre, thresh_r;
  logic [6:0]        bits;
  logic [A_W-1:0]    addr_hold;
  logic              last_px, nx_border, hs, cmp;

  assign hs      = (state == OUT) && lbp_valid && lbp_ready;
  assign last_px = (x == X_LAST) && (y == Y_LAST);
  // Sum is widened by one bit so centre + thresh never wraps; an overflowing sum can never be reached.
  assign cmp     = {1'b0, gray_data} >= ({1'b0, centre} + {1'b0, thresh_r});

  always_comb begin
    nx_x = x + X_ONE;
    nx_y = y;
    if (x == X_LAST) begin
      nx_x = X_FIRST;
      nx_y = y + Y_ONE;
    end
  end

`ifdef LBP_BORDER_EN
  assign nx_border = (nx_x == '0) || (nx_x == X_END) || (nx_y == '0) || (nx_y == Y_END);
`else
  assign nx_border = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = FIRST_BORDER ? OUT : FETCH;
      FETCH:   if (cnt == 4'd8) next_state = CALC;
      CALC:    next_state = OUT;
      OUT:     if (hs) next_state = last_px ? DONE : (nx_border ? OUT : FETCH);
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request order: centre first, then the eight neighbours in raster order.
  always_comb begin
    fy = y;
    fx = x;
    case (cnt)
      4'd1: begin fy = y - Y_ONE; fx = x - X_ONE; end
      4'd2: fy = y - Y_ONE;
      4'd3: begin fy = y - Y_ONE; fx = x + X_ONE; end
      4'd4: fx = x - X_ONE;
      4'd5: fx = x + X_ONE;
      4'd6: begin fy = y + Y_ONE; fx = x - X_ONE; end
      4'd7: fy = y + Y_ONE;
      4'd8: begin fy = y + Y_ONE; fx = x + X_ONE; end
      default: ;
    endcase
  end

  always_comb begin
    gray_req  = (state == FETCH);
    gray_addr = gray_req ? {fy, fx} : addr_hold;
    busy      = (state != IDLE);
    finish    = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x         <= X_FIRST;
      y         <= Y_FIRST;
      cnt       <= '0;
      centre    <= '0;
      thresh_r  <= '0;
      bits      <= '0;
      addr_hold <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
    end else begin
      cnt <= (state == FETCH) ? cnt + 4'd1 : '0;
      if (state == IDLE && start) thresh_r <= thresh;
      if (state == FETCH) addr_hold <= {fy, fx};
      // Read data trails its request by one cycle: centre lands at cnt 1, neighbour k at cnt k+1.
      if (state == FETCH && cnt == 4'd1) centre <= gray_data;
      if (state == FETCH && cnt >= 4'd2) bits <= {cmp, bits[6:1]};
      if (state == DONE) begin
        x <= X_FIRST;
        y <= Y_FIRST;
      end else if (hs && !last_px) begin
        x <= nx_x;
        y <= nx_y;
      end
      if (state == CALC) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= {y, x};
        lbp_data  <= {cmp, bits};
      end
`ifdef LBP_BORDER_EN
      else if (state == IDLE && start) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= {Y_FIRST, X_FIRST};
        lbp_data  <= '0;
      end else if (hs && !last_px && nx_border) begin
        lbp_valid <= 1'b1;
        lbp_addr  <= {nx_y, nx_x};
        lbp_data  <= '0;
      end
`endif
      else if (hs) lbp_valid <= 1'b0;
    end
  end
endmodule
